// File: rtl/rf_arb_pkg.sv
// Shared constants and grant-state type for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned W_DEF         = 8;
  localparam int unsigned D_DEF         = 4;
  localparam int unsigned DEPTH_DEF     = 2;
  localparam int unsigned PROT_ADDR_DEF = 14;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } grant_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Per-requester writeback queue: DEPTH entries, in-order, synchronous reset.
// Pushes into a full queue and pops from an empty queue are ignored.
module rf_wb_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter merging ALU (A) and load (B) writebacks into one RF write port.
// Define RF_WRITE_PROTECT_EN to drop writes to PROT_ADDR and pulse prot_hit instead.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned D         = D_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned PROT_ADDR = PROT_ADDR_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [D-1:0] a_addr,
  input  logic [W-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [D-1:0] b_addr,
  input  logic [W-1:0] b_data,
  output logic         WriteEn,
  output logic [D-1:0] reg_in,
  output logic [W-1:0] DataIn,
  output logic         busy,
  output logic         prot_hit
);

  localparam int unsigned EW = D + W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [D-1:0] PROT = D'(PROT_ADDR);
`ifdef RF_WRITE_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  logic [EW-1:0] a_dout, b_dout, head;
  logic [CW-1:0] a_cnt, b_cnt;
  logic          a_full, a_empty, b_full, b_empty;
  logic          gnt_a, gnt_b, gnt_any, drop;
  logic [D-1:0]  head_addr;
  logic [W-1:0]  head_data;

  grant_state_e  state_q;
  logic          we_q, prot_q;
  logic [D-1:0]  reg_q;
  logic [W-1:0]  data_q;

  // Ready reflects the pre-pop count, so a full queue refuses even while popping.
  assign a_ready = ~a_full;
  assign b_ready = ~b_full;

  rf_wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_a (
    .clk(Clk), .rst(Reset), .push(a_valid & a_ready), .pop(gnt_a),
    .din({a_addr, a_data}), .dout(a_dout), .count(a_cnt),
    .full(a_full), .empty(a_empty)
  );

  rf_wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_b (
    .clk(Clk), .rst(Reset), .push(b_valid & b_ready), .pop(gnt_b),
    .din({b_addr, b_data}), .dout(b_dout), .count(b_cnt),
    .full(b_full), .empty(b_empty)
  );

  // Round-robin pick; reset suppresses any grant on its edge.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!Reset) begin
      if (!a_empty && !b_empty) begin
        if (state_q == LAST_A) gnt_b = 1'b1;
        else                   gnt_a = 1'b1;
      end else if (!a_empty) begin
        gnt_a = 1'b1;
      end else if (!b_empty) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign gnt_any   = gnt_a | gnt_b;
  assign head      = gnt_b ? b_dout : a_dout;
  assign head_addr = head[EW-1:W];
  assign head_data = head[W-1:0];
  assign drop      = PROT_EN & (head_addr == PROT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= LAST_B;
      we_q    <= 1'b0;
      prot_q  <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      we_q   <= gnt_any & ~drop;
      prot_q <= gnt_any & drop;
      if (gnt_any) begin
        state_q <= gnt_b ? LAST_B : LAST_A;
        reg_q   <= head_addr;
        data_q  <= head_data;
      end
    end
  end

  assign WriteEn  = we_q;
  assign reg_in   = reg_q;
  assign DataIn   = data_q;
  assign prot_hit = prot_q;
  assign busy     = (a_cnt != '0) | (b_cnt != '0) | we_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and a shadow register file.
module tb_rf_write_arbiter;

  localparam int unsigned W     = 8;
  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PROT  = 14;
`ifdef RF_WRITE_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;
  logic [D-1:0] a_addr, b_addr;
  logic [W-1:0] a_data, b_data;
  logic         WriteEn, busy, prot_hit;
  logic [D-1:0] reg_in;
  logic [W-1:0] DataIn;

  rf_write_arbiter #(.W(W), .D(D), .DEPTH(DEPTH), .PROT_ADDR(PROT)) dut (
    .Clk(Clk), .Reset(Reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .WriteEn(WriteEn), .reg_in(reg_in), .DataIn(DataIn),
    .busy(busy), .prot_hit(prot_hit)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [D-1:0] a;
    logic [W-1:0] d;
  } ent_t;

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  ent_t         qa[$];
  ent_t         qb[$];
  bit           last_b;
  logic         exp_we, exp_ph;
  logic [D-1:0] exp_reg;
  logic [W-1:0] exp_data;
  logic [W-1:0] rf_dut [16];
  logic [W-1:0] rf_ref [16];
  logic [D-1:0] wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, predict the rising edge, check the next falling edge.
  task automatic step(input logic va, input logic [D-1:0] aa, input logic [W-1:0] da,
                      input logic vb, input logic [D-1:0] ab, input logic [W-1:0] db,
                      input logic rst);
    bit   ra, rb, pick_b;
    ent_t e;
    a_valid = va; a_addr = aa; a_data = da;
    b_valid = vb; b_addr = ab; b_data = db;
    Reset   = rst;
    #1;
    ra = (qa.size() < DEPTH);
    rb = (qb.size() < DEPTH);
    chk("a_ready", 32'(a_ready), 32'(ra));
    chk("b_ready", 32'(b_ready), 32'(rb));
    chk("busy", 32'(busy), 32'((qa.size() != 0) || (qb.size() != 0) || (exp_we == 1'b1)));
    if (rst) begin
      qa.delete(); qb.delete();
      last_b = 1'b1; exp_we = 1'b0; exp_ph = 1'b0; exp_reg = '0; exp_data = '0;
    end else begin
      exp_we = 1'b0;
      exp_ph = 1'b0;
      if (qa.size() != 0 || qb.size() != 0) begin
        pick_b = (qb.size() != 0) && ((qa.size() == 0) || !last_b);
        e      = pick_b ? qb.pop_front() : qa.pop_front();
        last_b = pick_b;
        exp_reg  = e.a;
        exp_data = e.d;
        if (PROT_ON && e.a == D'(PROT)) exp_ph = 1'b1;
        else begin
          exp_we = 1'b1;
          rf_ref[e.a] = e.d;
        end
      end
      if (va && ra) begin e.a = aa; e.d = da; qa.push_back(e); end
      if (vb && rb) begin e.a = ab; e.d = db; qb.push_back(e); end
    end
    @(posedge Clk);
    @(negedge Clk);
    chk("WriteEn", 32'(WriteEn), 32'(exp_we));
    chk("reg_in", 32'(reg_in), 32'(exp_reg));
    chk("DataIn", 32'(DataIn), 32'(exp_data));
    chk("prot_hit", 32'(prot_hit), 32'(exp_ph));
    if (WriteEn === 1'b1) begin
      rf_dut[reg_in] = DataIn;
      wlog.push_back(reg_in);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    wlog.delete();
  endtask

  initial begin
    logic [D-1:0] exp26 [4];
    logic [W-1:0] d27 [3];
    int           k, tries;
    bit           acc;

    for (int i = 0; i < 16; i++) begin rf_dut[i] = '0; rf_ref[i] = '0; end
    exp26 = '{4'd1, 4'd4, 4'd2, 4'd5};
    d27   = '{8'hA1, 8'hB2, 8'hC3};

    // Bring-up reset before any prediction is meaningful.
    Reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    qa.delete(); qb.delete();
    last_b = 1'b1; exp_we = 1'b0; exp_ph = 1'b0; exp_reg = '0; exp_data = '0;
    chk("rst_WriteEn", 32'(WriteEn), 32'd0);
    chk("rst_reg_in", 32'(reg_in), 32'd0);
    chk("rst_DataIn", 32'(DataIn), 32'd0);
    chk("rst_prot_hit", 32'(prot_hit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    wlog.delete();

    // Single A write, 2-edge latency.
    step(1'b1, 4'd3, 8'h5A, 1'b0, '0, '0, 1'b0);
    idle(3);
    chk("single_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) chk("single_addr", 32'(wlog[0]), 32'd3);
    chk("single_data", 32'(rf_dut[3]), 32'h5A);

    // Interleaved A/B pushes alternate grants.
    do_reset();
    step(1'b1, 4'd1, 8'h11, 1'b1, 4'd4, 8'h44, 1'b0);
    step(1'b1, 4'd2, 8'h22, 1'b1, 4'd5, 8'h55, 1'b0);
    idle(5);
    chk("rr_count", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) chk($sformatf("rr_order%0d", i), 32'(wlog[i]), 32'(exp26[i]));

    // Three back-to-back A writes, each held until accepted.
    do_reset();
    for (k = 0; k < 3; k++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 10) begin
        acc = (qa.size() < DEPTH);
        step(1'b1, 4'(8 + k), d27[k], 1'b0, '0, '0, 1'b0);
        tries++;
      end
      chk($sformatf("burst_accept%0d", k), 32'(acc), 32'd1);
    end
    idle(5);
    chk("burst_count", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < wlog.size()) chk($sformatf("burst_order%0d", i), 32'(wlog[i]), 32'(8 + i));

    // Same-address collision: A first, B wins.
    do_reset();
    step(1'b1, 4'd7, 8'h01, 1'b1, 4'd7, 8'h02, 1'b0);
    idle(4);
    chk("collide_count", 32'(wlog.size()), 32'd2);
    chk("collide_final", 32'(rf_dut[7]), 32'h02);

    // Reset with entries queued discards them.
    do_reset();
    step(1'b1, 4'd2, 8'h77, 1'b1, 4'd6, 8'h66, 1'b0);
    do_reset();
    idle(3);
    chk("flush_writes", 32'(wlog.size()), 32'd0);

    // Write to the protected address.
    do_reset();
    step(1'b1, 4'(PROT), 8'h00, 1'b0, '0, '0, 1'b0);
    idle(3);
    chk("prot_writes", 32'(wlog.size()), PROT_ON ? 32'd0 : 32'd1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(1'(($urandom % 4) != 0), D'($urandom), W'($urandom),
           1'(($urandom % 3) != 0), D'($urandom), W'($urandom),
           1'(($urandom % 60) == 0));
    end
    idle(6);
    for (int i = 0; i < 16; i++)
      chk($sformatf("rf%0d", i), 32'(rf_dut[i]), 32'(rf_ref[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
